// File: rtl/cordic_sign_replay_if.sv
// rtl/cordic_sign_replay_if.sv - control/status bundle between the sign replay store and its neighbours
// play_hold exists only when SIGN_REPLAY_HOLD_EN is defined.
interface cordic_sign_replay_if #(
    parameter int WIDTH_SHIFT_BIT = 4
);
    logic                       cap_start;
    logic                       cap_vld;
    logic                       sign_cap;
    logic                       play_start;
    logic                       play_inv;
`ifdef SIGN_REPLAY_HOLD_EN
    logic                       play_hold;
`endif
    logic                       ce_out;
    logic                       sign_out;
    logic [WIDTH_SHIFT_BIT-1:0] iter_idx;
    logic                       seq_valid;
    logic                       cap_done;
    logic                       play_done;
    logic                       busy;

    modport master (
`ifdef SIGN_REPLAY_HOLD_EN
        output play_hold,
`endif
        output cap_start, cap_vld, sign_cap, play_start, play_inv,
        input  ce_out, sign_out, iter_idx, seq_valid, cap_done, play_done, busy
    );

    modport slave (
`ifdef SIGN_REPLAY_HOLD_EN
        input  play_hold,
`endif
        input  cap_start, cap_vld, sign_cap, play_start, play_inv,
        output ce_out, sign_out, iter_idx, seq_valid, cap_done, play_done, busy
    );
endinterface

// File: rtl/cordic_sign_replay.sv
// rtl/cordic_sign_replay.sv - capture/replay store for CORDIC micro-rotation directions
// Optional replay stall input enabled by SIGN_REPLAY_HOLD_EN.
module cordic_sign_replay #(
    parameter int ITER            = 16,
    parameter int WIDTH_SHIFT_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_sign_replay_if.slave   bus
);
    localparam logic [WIDTH_SHIFT_BIT-1:0] LAST = WIDTH_SHIFT_BIT'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, READY, PLAY} state_t;

    state_t                     state;
    logic [ITER-1:0]            store;
    logic [WIDTH_SHIFT_BIT-1:0] cnt;
    logic                       inv;
    logic                       ce_r;
    logic                       sign_r;
    logic [WIDTH_SHIFT_BIT-1:0] idx_r;
    logic                       seq_valid_r;
    logic                       cap_done_r;
    logic                       play_done_r;
    logic                       busy_r;
    logic                       hold;
    logic [WIDTH_SHIFT_BIT-1:0] pend;

`ifdef SIGN_REPLAY_HOLD_EN
    assign hold = bus.play_hold;
`else
    assign hold = 1'b0;
`endif

    // In PLAY, cnt names the bit on sign_out; it was only consumed if ce_out was high.
    assign pend = ce_r ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            store       <= '0;
            cnt         <= '0;
            inv         <= 1'b0;
            ce_r        <= 1'b0;
            sign_r      <= 1'b0;
            idx_r       <= '0;
            seq_valid_r <= 1'b0;
            cap_done_r  <= 1'b0;
            play_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cap_done_r  <= 1'b0;
            play_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cap_start) begin
                        state  <= CAPTURE;
                        cnt    <= '0;
                        store  <= '0;
                        busy_r <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bus.cap_vld) begin
                        store[cnt] <= bus.sign_cap;
                        if (cnt == LAST) begin
                            state       <= READY;
                            cnt         <= '0;
                            cap_done_r  <= 1'b1;
                            seq_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (bus.cap_start) begin
                        state       <= CAPTURE;
                        cnt         <= '0;
                        store       <= '0;
                        seq_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else if (bus.play_start) begin
                        // First bit is presented straight away so ce_out rises the next cycle.
                        state  <= PLAY;
                        inv    <= bus.play_inv;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        ce_r   <= 1'b1;
                        sign_r <= store[0] ^ bus.play_inv;
                        idx_r  <= '0;
                    end
                end
                PLAY: begin
                    if (ce_r && cnt == LAST) begin
                        state       <= READY;
                        cnt         <= '0;
                        ce_r        <= 1'b0;
                        sign_r      <= 1'b0;
                        idx_r       <= '0;
                        play_done_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt    <= pend;
                        idx_r  <= pend;
                        sign_r <= store[pend] ^ inv;
                        ce_r   <= !hold;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ce_out    = ce_r;
    assign bus.sign_out  = sign_r;
    assign bus.iter_idx  = idx_r;
    assign bus.seq_valid = seq_valid_r;
    assign bus.cap_done  = cap_done_r;
    assign bus.play_done = play_done_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_cordic_sign_replay.sv
// tb/tb_cordic_sign_replay.sv - randomized self-checking bench for cordic_sign_replay
// Exercises play_hold when built with SIGN_REPLAY_HOLD_EN.
module tb_cordic_sign_replay;
    localparam int ITER = 16;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_sign_replay_if #(.WIDTH_SHIFT_BIT(W)) bus ();
    cordic_sign_replay #(.ITER(ITER), .WIDTH_SHIFT_BIT(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [ITER-1:0] model_bits;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.cap_start  = 1'b0;
        bus.cap_vld    = 1'b0;
        bus.sign_cap   = 1'b0;
        bus.play_start = 1'b0;
        bus.play_inv   = 1'b0;
`ifdef SIGN_REPLAY_HOLD_EN
        bus.play_hold  = 1'b0;
`endif
    endtask

    task automatic test_reset;
        logic [W+5:0] outs;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        outs = {bus.ce_out, bus.sign_out, bus.iter_idx, bus.seq_valid, bus.cap_done, bus.play_done, bus.busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", outs);
        end
        rst = 1'b0;
        bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        tick();
        outs = {bus.ce_out, bus.sign_out, bus.iter_idx, bus.seq_valid, bus.cap_done, bus.play_done, bus.busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL idle_ignores_play got %b want 0", outs);
        end
    endtask

    task automatic do_capture(input logic [ITER-1:0] bits, input bit stalls, input bit collide, input string name);
        int   n;
        int   cyc;
        logic vld;
        bus.cap_start  = 1'b1;
        bus.play_start = collide;
        tick();
        bus.cap_start  = 1'b0;
        bus.play_start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.seq_valid !== 1'b0 || bus.ce_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_start busy/seq_valid/ce got %b%b%b want 100", name, bus.busy, bus.seq_valid, bus.ce_out);
        end
        n   = 0;
        cyc = 0;
        while (n < ITER && cyc < 400) begin
            vld            = stalls ? ($urandom_range(0, 2) == 0) : 1'b1;
            bus.cap_vld    = vld;
            bus.sign_cap   = vld ? bits[n] : 1'($urandom_range(0, 1));
            bus.play_start = stalls ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.cap_start  = stalls ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            cyc++;
            if (vld) n++;
            if (n < ITER) begin
                checks++;
                if (bus.cap_done !== 1'b0 || bus.seq_valid !== 1'b0 || bus.ce_out !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_mid n=%0d done/valid/ce/busy got %b%b%b%b want 0001", name, n,
                             bus.cap_done, bus.seq_valid, bus.ce_out, bus.busy);
                end
            end
        end
        clear_inputs();
        checks++;
        if (n < ITER) begin
            errors++;
            $display("FAIL %s_timeout got %0d bits want %0d", name, n, ITER);
        end
        checks++;
        if (bus.cap_done !== 1'b1 || bus.seq_valid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done done/valid/busy got %b%b%b want 110", name, bus.cap_done, bus.seq_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.cap_done !== 1'b0 || bus.seq_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_after done/valid got %b%b want 01", name, bus.cap_done, bus.seq_valid);
        end
        model_bits = bits;
    endtask

    // Expected stream: every captured bit in order (negated if inv), with hold_len idle
    // cycles parked on bit hold_at, then one play_done cycle.
    task automatic do_play(input bit inv, input int hold_at, input int hold_len, input string name);
        logic exp_ce[$];
        int   exp_idx[$];
        logic exp_sign[$];
        logic [ITER-1:0] got;
        logic [ITER-1:0] want;
        int   sz;
        for (int k = 0; k < ITER; k++) begin
            if (k == hold_at) begin
                for (int h = 0; h < hold_len; h++) begin
                    exp_ce.push_back(1'b0);
                    exp_idx.push_back(k);
                    exp_sign.push_back(model_bits[k] ^ inv);
                end
            end
            exp_ce.push_back(1'b1);
            exp_idx.push_back(k);
            exp_sign.push_back(model_bits[k] ^ inv);
        end
        exp_ce.push_back(1'b0);
        exp_idx.push_back(0);
        exp_sign.push_back(1'b0);
        sz  = exp_ce.size();
        got = '0;

        bus.play_inv   = inv;
        bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        for (int j = 0; j < sz; j++) begin
            checks++;
            if (bus.ce_out !== exp_ce[j] || int'(bus.iter_idx) != exp_idx[j] || bus.sign_out !== exp_sign[j]) begin
                errors++;
                $display("FAIL %s_bit cycle=%0d ce/idx/sign got %b/%0d/%b want %b/%0d/%b", name, j + 1,
                         bus.ce_out, bus.iter_idx, bus.sign_out, exp_ce[j], exp_idx[j], exp_sign[j]);
            end
            checks++;
            if (bus.play_done !== (j == sz - 1) || bus.busy !== (j != sz - 1) || bus.seq_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_status cycle=%0d done/busy/valid got %b%b%b want %b%b1", name, j + 1,
                         bus.play_done, bus.busy, bus.seq_valid, j == sz - 1, j != sz - 1);
            end
            if (bus.ce_out === 1'b1) got[bus.iter_idx] = bus.sign_out;
            if (j < sz - 1) begin
                bus.play_inv   = 1'($urandom_range(0, 1));
                bus.play_start = 1'($urandom_range(0, 1));
                bus.cap_start  = 1'($urandom_range(0, 1));
`ifdef SIGN_REPLAY_HOLD_EN
                bus.play_hold  = (j + 1 >= hold_at) && (j + 1 < hold_at + hold_len);
`endif
                tick();
            end
        end
        clear_inputs();
        want = inv ? ~model_bits : model_bits;
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s_vector got %b want %b", name, got, want);
        end
    endtask

    task automatic test_capture;
        do_capture(16'b1011_0010_1110_0001, 1'b0, 1'b0, "capture");
    endtask

    task automatic test_forward;
        do_play(1'b0, ITER, 0, "forward");
    endtask

    task automatic test_inverse;
        do_play(1'b1, ITER, 0, "inverse");
        checks++;
        if ((~model_bits) !== 16'b0100_1101_0001_1110) begin
            errors++;
            $display("FAIL inverse_pattern got %b want 0100110100011110", ~model_bits);
        end
    endtask

    task automatic test_stalled_capture;
        do_capture(16'($urandom), 1'b1, 1'b0, "stalled");
        do_play(1'($urandom_range(0, 1)), ITER, 0, "stalled_play");
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 4; r++) do_play(1'($urandom_range(0, 1)), ITER, 0, "b2b");
    endtask

    task automatic test_collision;
        do_capture(16'($urandom), 1'b0, 1'b1, "collision");
        do_play(1'b0, ITER, 0, "collision_play");
    endtask

    task automatic test_hold;
`ifdef SIGN_REPLAY_HOLD_EN
        do_play(1'b0, 5, 3, "hold");
        do_play(1'b1, 1 + int'($urandom_range(0, ITER - 2)), 1 + int'($urandom_range(0, 4)), "hold_rand");
`else
        do_play(1'b0, ITER, 0, "nohold");
`endif
    endtask

    task automatic test_abort;
        logic [W+5:0] outs;
        bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        repeat (7) tick();
        checks++;
        if (bus.ce_out !== 1'b1 || bus.iter_idx !== 4'd7) begin
            errors++;
            $display("FAIL abort_pre ce/idx got %b/%0d want 1/7", bus.ce_out, bus.iter_idx);
        end
        #2 rst = 1'b1;
        #1;
        outs = {bus.ce_out, bus.sign_out, bus.iter_idx, bus.seq_valid, bus.cap_done, bus.play_done, bus.busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL abort_async got %b want 0", outs);
        end
        tick();
        rst = 1'b0;
        bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        tick();
        checks++;
        if (bus.ce_out !== 1'b0 || bus.busy !== 1'b0 || bus.seq_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle ce/busy/valid got %b%b%b want 000", bus.ce_out, bus.busy, bus.seq_valid);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_inverse();
        test_stalled_capture();
        test_back_to_back();
        test_collision();
        test_hold();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
